reg_access_ctrl: RTL and testbench

Bus-side access controller that sits directly upstream of a bank of tristate-output storage registers. Each register has an input bus, a write enable, an output enable and a high-Z output.
- Accepts single read/write requests over a valid/ready handshake.
- Drives the shared write-data bus and one-hot per-register we/oe strobes.
- Samples the shared read bus and returns read data over a valid/ready response channel.
- Never asserts we and oe together, and never asserts oe on more than one register, so the shared bus is never contended.

---
 rtl/reg_access_ctrl.sv | 133 +++++++++++++
 tb/tb_reg_access_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: single-request bus controller for a bank of tristate-output registers.
// Latency: write strobe 1 cycle after accept; read response valid 2 cycles after accept.
// Backpressure: req_ready only in IDLE; a read response is held in RESP until rsp_ready.
// Optional feature macro: REG_ACCESS_CTRL_READBACK_EN (read-back verify after every write, sticky o_w_wr_err).
module reg_access_ctrl #(
  parameter int p_data_width = 7,
  parameter int p_addr_width = 2
) (
  input  logic                              i_w_clk,
  input  logic                              i_w_reset,
  input  logic                              i_w_req_valid,
  output logic                              o_w_req_ready,
  input  logic                              i_w_req_wr,
  input  logic [p_addr_width-1:0]           i_w_req_addr,
  input  logic [p_data_width-1:0]           i_w_req_wdata,
  output logic                              o_w_rsp_valid,
  input  logic                              i_w_rsp_ready,
  output logic [p_data_width-1:0]           o_w_rsp_rdata,
  output logic [p_data_width-1:0]           o_w_bus_data,
  output logic [(1<<p_addr_width)-1:0]      o_w_we,
  output logic [(1<<p_addr_width)-1:0]      o_w_oe,
  input  logic [p_data_width-1:0]           i_w_bus_rdata,
  output logic                              o_w_wr_err
);

  localparam int N = 1 << p_addr_width;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RESP,
    S_VERIFY
  } state_t;

  state_t state;

  // One-hot decode of the incoming address, registered into we/oe at accept.
  logic [N-1:0] req_onehot;
  assign req_onehot = N'(1) << i_w_req_addr;

`ifndef REG_ACCESS_CTRL_READBACK_EN
  assign o_w_wr_err = 1'b0;
`endif

  // Whole controller: state plus every strobe/handshake output registered, so
  // we/oe come straight off flops and reset clears them without waiting for a clock.
  // The latched write data lives in o_w_bus_data and the latched address in
  // o_w_we, which is why no separate addr/wdata copies are kept.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      state         <= S_IDLE;
      o_w_req_ready <= 1'b0;
      o_w_rsp_valid <= 1'b0;
      o_w_rsp_rdata <= '0;
      o_w_bus_data  <= '0;
      o_w_we        <= '0;
      o_w_oe        <= '0;
`ifdef REG_ACCESS_CTRL_READBACK_EN
      o_w_wr_err    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // req_ready comes up on the first edge after reset release; accept only once it is seen high
          if (o_w_req_ready && i_w_req_valid) begin
            o_w_req_ready <= 1'b0;
            if (i_w_req_wr) begin
              state        <= S_WRITE;
              o_w_we       <= req_onehot;
              o_w_bus_data <= i_w_req_wdata;
            end else begin
              state  <= S_READ;
              o_w_oe <= req_onehot;
            end
          end else begin
            o_w_req_ready <= 1'b1;
          end
        end

        S_WRITE: begin
          o_w_we <= '0;
`ifdef REG_ACCESS_CTRL_READBACK_EN
          // reuse the write strobe pattern as the read-back select
          state  <= S_VERIFY;
          o_w_oe <= o_w_we;
`else
          state         <= S_IDLE;
          o_w_bus_data  <= '0;
          o_w_req_ready <= 1'b1;
`endif
        end

`ifdef REG_ACCESS_CTRL_READBACK_EN
        S_VERIFY: begin
          if (i_w_bus_rdata != o_w_bus_data) begin
            o_w_wr_err <= 1'b1;
          end
          o_w_oe        <= '0;
          o_w_bus_data  <= '0;
          state         <= S_IDLE;
          o_w_req_ready <= 1'b1;
        end
`endif

        S_READ: begin
          o_w_oe        <= '0;
          o_w_rsp_rdata <= i_w_bus_rdata;
          o_w_rsp_valid <= 1'b1;
          state         <= S_RESP;
        end

        S_RESP: begin
          if (i_w_rsp_ready) begin
            o_w_rsp_valid <= 1'b0;
            o_w_req_ready <= 1'b1;
            state         <= S_IDLE;
          end
        end

        default: begin
          state         <= S_IDLE;
          o_w_we        <= '0;
          o_w_oe        <= '0;
          o_w_bus_data  <= '0;
          o_w_rsp_valid <= 1'b0;
          o_w_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: storage-register bank model on the bus side,
// table-driven directed transactions, hand-written corner sequences, then
// random traffic checked against a plain array model of register contents.
module tb_reg_access_ctrl;

  localparam int DW = 7;
  localparam int AW = 2;
  localparam int N  = 4;
`ifdef REG_ACCESS_CTRL_READBACK_EN
  localparam int WR_SP = 3;
`else
  localparam int WR_SP = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_wr, rsp_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, rsp_valid, wr_err;
  logic [DW-1:0] rsp_rdata, bus_data, bus_rdata;
  logic [N-1:0]  we, oe;

  logic [DW-1:0] regs [N];
  bit            corrupt = 1'b0;
  logic [DW-1:0] mem [N];
  int            n_cmp = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  reg_access_ctrl dut (
    .i_w_clk       (clk),
    .i_w_reset     (rst_n),
    .i_w_req_valid (req_valid),
    .o_w_req_ready (req_ready),
    .i_w_req_wr    (req_wr),
    .i_w_req_addr  (req_addr),
    .i_w_req_wdata (req_wdata),
    .o_w_rsp_valid (rsp_valid),
    .i_w_rsp_ready (rsp_ready),
    .o_w_rsp_rdata (rsp_rdata),
    .o_w_bus_data  (bus_data),
    .o_w_we        (we),
    .o_w_oe        (oe),
    .i_w_bus_rdata (bus_rdata),
    .o_w_wr_err    (wr_err)
  );

  // Storage registers: capture the input bus on posedge when their we is high.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (we[i]) regs[i] <= bus_data;
  end

  // Resolved tristate bus: the enabled register drives it, otherwise pulled to 0.
  always_comb begin
    bus_rdata = '0;
    for (int i = 0; i < N; i++)
      if (oe[i]) bus_rdata = regs[i];
    if (corrupt) bus_rdata = bus_rdata ^ 7'h01;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input logic [AW-1:0] a);
    logic [N-1:0] r;
    r = '0;
    r[a] = 1'b1;
    return r;
  endfunction

  // Bus safety invariant, sampled every cycle.
  always @(negedge clk) begin
    chk("we_oe_overlap", 32'(we & oe), 32'd0);
    chk("oe_at_most_one", 32'($countones(oe) <= 1), 32'd1);
  end

  task automatic wait_ready();
    int k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wr_we",        32'(we), 32'(oh(a)));
    chk("wr_oe",        32'(oe), 32'd0);
    chk("wr_bus_data",  32'(bus_data), 32'(d));
    chk("wr_req_ready", 32'(req_ready), 32'd0);
`ifdef REG_ACCESS_CTRL_READBACK_EN
    @(negedge clk);
    chk("vfy_oe", 32'(oe), 32'(oh(a)));
    chk("vfy_we", 32'(we), 32'd0);
    chk("vfy_rsp_valid", 32'(rsp_valid), 32'd0);
`endif
    @(negedge clk);
    chk("wr_done_we",    32'(we), 32'd0);
    chk("wr_done_ready", 32'(req_ready), 32'd1);
    chk("wr_no_rsp",     32'(rsp_valid), 32'd0);
    mem[a] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int dly, input logic [DW-1:0] exp);
    wait_ready();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_wdata = $urandom_range(0, 127);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rd_oe",        32'(oe), 32'(oh(a)));
    chk("rd_we",        32'(we), 32'd0);
    chk("rd_rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp));
    chk("rsp_oe",    32'(oe), 32'd0);
    rsp_ready = (dly == 0);
    for (int i = 1; i <= dly; i++) begin
      @(negedge clk);
      chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_hold_rdata", 32'(rsp_rdata), 32'(exp));
      if (i == dly) rsp_ready = 1'b1;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_dropped", 32'(rsp_valid), 32'd0);
    chk("rd_done_ready", 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;   // write data, or expected read data
    int            dly;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 2'd0, 7'h11, 0};
    vecs[1] = '{1'b1, 2'd1, 7'h22, 0};
    vecs[2] = '{1'b1, 2'd2, 7'h55, 0};
    vecs[3] = '{1'b1, 2'd3, 7'h7F, 0};
    vecs[4] = '{1'b0, 2'd2, 7'h55, 3};
    vecs[5] = '{1'b0, 2'd3, 7'h7F, 0};
    vecs[6] = '{1'b1, 2'd3, 7'h00, 0};
    vecs[7] = '{1'b0, 2'd3, 7'h00, 1};
    vecs[8] = '{1'b0, 2'd0, 7'h11, 2};
    vecs[9] = '{1'b0, 2'd1, 7'h22, 0};

    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_we",        32'(we), 32'd0);
    chk("rst_oe",        32'(oe), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_bus_data",  32'(bus_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("post_rst_err",   32'(wr_err), 32'd0);
    chk("post_rst_we_oe", 32'({we, oe}), 32'd0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
      else            do_read(vecs[i].addr, vecs[i].dly, vecs[i].data);
    end

    // Back-to-back with req_valid held: write addr0 then read addr0
    begin
      int k;
      wait_ready();
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 2'd0; req_wdata = 7'h01;
      @(negedge clk);
      chk("b2b_we", 32'(we), 32'(oh(2'd0)));
      req_wr = 1'b0;
      k = 1;
      while (!req_ready && k < 10) begin
        @(negedge clk);
        k++;
      end
      chk("b2b_spacing", 32'(k), 32'(WR_SP));
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b_rd_oe", 32'(oe), 32'(oh(2'd0)));
      @(negedge clk);
      chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("b2b_rdata",     32'(rsp_rdata), 32'h01);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("b2b_rsp_done", 32'(rsp_valid), 32'd0);
      mem[0] = 7'h01;
    end

    // Random traffic against the array model
    for (int t = 0; t < 60; t++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, N - 1));
      if ($urandom_range(0, 1) == 1) do_write(a, DW'($urandom_range(0, 127)));
      else                           do_read(a, $urandom_range(0, 2), mem[a]);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
`ifndef REG_ACCESS_CTRL_READBACK_EN
    chk("wr_err_tied_low", 32'(wr_err), 32'd0);
`endif

    // Reset in the middle of the READ cycle
    wait_ready();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 2'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_rd_oe", 32'(oe), 32'(oh(2'd3)));
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_oe", 32'(oe), 32'd0);
    chk("async_rst_we", 32'(we), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_no_rsp", 32'(rsp_valid), 32'd0);
      chk("post_abort_idle",   32'(req_ready), 32'd1);
    end

`ifdef REG_ACCESS_CTRL_READBACK_EN
    // Read-back mismatch is sticky until reset
    corrupt = 1'b1;
    do_write(2'd1, 7'h2A);
    corrupt = 1'b0;
    chk("rb_err_set", 32'(wr_err), 32'd1);
    do_write(2'd2, 7'h10);
    chk("rb_err_sticky", 32'(wr_err), 32'd1);
    do_read(2'd1, 0, 7'h2A);
    rst_n = 1'b0;
    #1;
    chk("rb_err_cleared", 32'(wr_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_write(2'd1, 7'h3C);
    chk("rb_err_clean_write", 32'(wr_err), 32'd0);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
